counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, counter data width; SHALL match the controlled counter's WIDTH.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  2  per-requester command valid; bit i is requester i.
REQ-005 req_ready  out  2  per-requester accept; a command transfers when req_valid[i] and req_ready[i] are both high at a clk edge.
REQ-006 req0_start, req1_start  in  WIDTH  preload value per requester.
REQ-007 req0_mode, req1_mode  in  1  direction per requester: 1 = up, 0 = down.
REQ-008 req0_steps, req1_steps  in  WIDTH  number of enable cycles requested.
REQ-009 ctr_enable, ctr_preload, ctr_mode  out  1  drive counter enable, preload and mode.
REQ-010 ctr_preload_data  out  WIDTH  drives counter preload_data.
REQ-011 ctr_detect  in  1  counter detect flag.
REQ-012 ctr_result  in  WIDTH  counter result.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 done_id  out  1  requester index of the completed command; valid while done is high.
REQ-016 done_result  out  WIDTH  equals ctr_result while done is high, 0 otherwise.
REQ-017 done_early  out  1  high with done when the run ended on ctr_detect.

Function
REQ-018 The FSM SHALL have four states: IDLE, LOAD, RUN and DONE.
REQ-019 IDLE: req_ready SHALL be combinational and one-hot for the round-robin winner among asserted req_valid bits; it SHALL be 0 when no request is valid; on transfer the block SHALL capture start/mode/steps and go to LOAD.
REQ-020 Round-robin arbitration:
- With one valid requester, that requester wins.
- With both valid, the requester not equal to last_grant wins.
- last_grant SHALL update only on transfer.
REQ-021 In LOAD, for exactly one cycle: ctr_preload=1, ctr_preload_data=captured start, ctr_mode=captured mode, ctr_enable=0.
REQ-022 From LOAD the FSM SHALL go to DONE if steps==0, else to RUN with remaining=steps.
REQ-023 RUN behaviour:
- Every cycle: ctr_enable=1, ctr_preload=0, ctr_mode=captured mode.
- remaining SHALL decrement by 1 per cycle.
- When remaining==1 the next state SHALL be DONE, giving exactly steps enable cycles.
REQ-024 In DONE, for one cycle: done=1 and done_id=the granted requester; next state SHALL be IDLE.
REQ-025 req_ready SHALL be 00 in LOAD, RUN and DONE; requests presented while busy SHALL wait, with no loss or reorder.
REQ-026 Outside LOAD and RUN, ctr_enable, ctr_preload, ctr_mode and ctr_preload_data SHALL be 0.
REQ-027 Steps SHALL be unsigned; steps=2^WIDTH-1 SHALL produce 2^WIDTH-1 enable cycles with no wrap of remaining.
REQ-028 Latency from transfer to done SHALL be steps+2 cycles.

Reset
REQ-029 While reset is high, regardless of clk:
- State SHALL be IDLE.
- remaining, captured fields and all outputs SHALL be 0.
- last_grant SHALL be 1, so requester 0 wins the first tie.
REQ-030 Reset asserted mid-command SHALL abort the command with no done pulse.

Configuration
REQ-031 Macro COUNTER_CTRL_DETECT_STOP_EN defined: ctr_detect sampled high in RUN with remaining>1 SHALL force next state DONE and set done_early=1 in DONE.
REQ-032 Macro undefined: ctr_detect SHALL be ignored, runs SHALL complete all steps, and done_early SHALL be tied 0.

Verification (WIDTH=4, paired with the team counter; a stub counter is used for ctr_detect in V5)
REQ-033 V1: assert reset during activity -> all outputs 0 immediately; after release, busy=0 and req_ready=00 with no requests.
REQ-034 V2: req0 start=3, mode=1, steps=4 -> req_ready=01 in the request cycle, one preload cycle with data 3, 4 enable cycles, then done=1, done_id=0, done_result=7; total 6 cycles.
REQ-035 V3: both requests valid after reset -> req0 served first, then req1; the next tie goes to req0.
REQ-036 V4: req1 start=9, mode=0, steps=0 -> LOAD then DONE, no enable cycle, done_id=1, done_result=9.
REQ-037 V5: stub drives ctr_detect=1 in the 2nd RUN cycle, steps=5 -> with the macro: done after 2 enables, done_early=1; without the macro: 5 enables, done_early=0.
REQ-038 V6: reset pulsed in the 3rd RUN cycle -> ctr_enable=0 at once, no done pulse, and the next request is served normally.

Source files
------------

// File: rtl/counter_ctrl.sv
// Sequencer that arbitrates two requesters and drives a preloadable up/down counter.
// Optional early stop on ctr_detect: define COUNTER_CTRL_DETECT_STOP_EN.
module counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_start,
    input  logic [WIDTH-1:0] req1_start,
    input  logic             req0_mode,
    input  logic             req1_mode,
    input  logic [WIDTH-1:0] req0_steps,
    input  logic [WIDTH-1:0] req1_steps,
    output logic             ctr_enable,
    output logic             ctr_preload,
    output logic             ctr_mode,
    output logic [WIDTH-1:0] ctr_preload_data,
    input  logic             ctr_detect,
    input  logic [WIDTH-1:0] ctr_result,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] done_result,
    output logic             done_early
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready offered to round-robin winner
    // LOAD  | one cycle preloading the counter with the captured start
    // RUN   | counter enabled, remaining counts down the requested steps
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  remaining, remaining_nxt;
    logic [WIDTH-1:0]  cap_start, cap_steps;
    logic              cap_mode, cap_id;
    logic              last_grant;
    logic [1:0]        grant;
    logic              transfer;

    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = (state == IDLE && !reset) ? grant : 2'b00;
    assign transfer  = |(req_valid & req_ready);
    assign busy      = (state != IDLE);

`ifdef COUNTER_CTRL_DETECT_STOP_EN
    logic early_r, early_nxt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            cap_start  <= '0;
            cap_steps  <= '0;
            cap_mode   <= 1'b0;
            cap_id     <= 1'b0;
            last_grant <= 1'b1;
`ifdef COUNTER_CTRL_DETECT_STOP_EN
            early_r    <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
`ifdef COUNTER_CTRL_DETECT_STOP_EN
            early_r   <= early_nxt;
`endif
            if (transfer) begin
                cap_start  <= req_ready[1] ? req1_start : req0_start;
                cap_mode   <= req_ready[1] ? req1_mode  : req0_mode;
                cap_steps  <= req_ready[1] ? req1_steps : req0_steps;
                cap_id     <= req_ready[1];
                last_grant <= req_ready[1];
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        remaining_nxt    = remaining;
        ctr_enable       = 1'b0;
        ctr_preload      = 1'b0;
        ctr_mode         = 1'b0;
        ctr_preload_data = '0;
        done             = 1'b0;
        done_id          = 1'b0;
`ifdef COUNTER_CTRL_DETECT_STOP_EN
        early_nxt        = early_r;
`endif
        unique case (state)
            IDLE: begin
                if (transfer) begin
                    state_nxt = LOAD;
`ifdef COUNTER_CTRL_DETECT_STOP_EN
                    early_nxt = 1'b0;
`endif
                end
            end
            LOAD: begin
                ctr_preload      = 1'b1;
                ctr_preload_data = cap_start;
                ctr_mode         = cap_mode;
                remaining_nxt    = cap_steps;
                state_nxt        = (cap_steps == '0) ? DONE : RUN;
            end
            RUN: begin
                ctr_enable    = 1'b1;
                ctr_mode      = cap_mode;
                remaining_nxt = remaining - WIDTH'(1);
                if (remaining == WIDTH'(1)) begin
                    state_nxt = DONE;
                end
`ifdef COUNTER_CTRL_DETECT_STOP_EN
                else if (ctr_detect) begin
                    state_nxt = DONE;
                    early_nxt = 1'b1;
                end
`endif
            end
            DONE: begin
                done      = 1'b1;
                done_id   = cap_id;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign done_result = done ? ctr_result : '0;

`ifdef COUNTER_CTRL_DETECT_STOP_EN
    assign done_early = done & early_r;
`else
    // Detect has no effect in this build; keep the port for drop-in pin compatibility.
    logic unused_detect;
    assign unused_detect = ctr_detect;
    assign done_early    = 1'b0;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl with a behavioural counter stub and timeline model.
module tb_counter_ctrl;
    localparam int W = 4;
`ifdef COUNTER_CTRL_DETECT_STOP_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid, req_ready;
    logic [W-1:0] req0_start, req1_start, req0_steps, req1_steps;
    logic         req0_mode, req1_mode;
    logic         ctr_enable, ctr_preload, ctr_mode;
    logic [W-1:0] ctr_preload_data, ctr_result;
    logic         ctr_detect;
    logic         busy, done, done_id, done_early;
    logic [W-1:0] done_result;

    always #5 clk = ~clk;

    counter_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req0_start(req0_start), .req1_start(req1_start),
        .req0_mode(req0_mode), .req1_mode(req1_mode),
        .req0_steps(req0_steps), .req1_steps(req1_steps),
        .ctr_enable(ctr_enable), .ctr_preload(ctr_preload), .ctr_mode(ctr_mode),
        .ctr_preload_data(ctr_preload_data), .ctr_detect(ctr_detect),
        .ctr_result(ctr_result), .busy(busy), .done(done), .done_id(done_id),
        .done_result(done_result), .done_early(done_early)
    );

    // counter stub
    logic [W-1:0] cnt;
    always @(posedge clk or posedge reset) begin
        if (reset)            cnt <= '0;
        else if (ctr_preload) cnt <= ctr_preload_data;
        else if (ctr_enable)  cnt <= ctr_mode ? cnt + W'(1) : cnt - W'(1);
    end
    assign ctr_result = cnt;

    typedef struct {
        logic [W-1:0] start;
        logic         mode;
        logic [W-1:0] steps;
        logic         det;
    } cmd_t;

    typedef struct {
        logic         id;
        logic [W-1:0] start;
        logic         mode;
        logic [W-1:0] result;
        int           enables;
        logic         early;
        int           lat;
        int           t0;
    } exp_t;

    cmd_t pend0[$], pend1[$];
    exp_t sb[$];
    exp_t cur;
    int   vectors = 0, miscompares = 0;
    int   cyc = 0, busy_left = 0, det_cnt = 0, xfers = 0, en_seen = 0;
    logic last = 1'b1;

    function automatic logic [1:0] rr(logic [1:0] v, logic l);
        case (v)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return l ? 2'b01 : 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic exp_t predict(logic id, cmd_t c, int t0);
        exp_t         e;
        logic [W-1:0] n;
        e.id      = id;
        e.start   = c.start;
        e.mode    = c.mode;
        e.early   = STOP_EN && c.det && (c.steps >= 3);
        e.enables = e.early ? 2 : int'(c.steps);
        n         = W'(e.enables);
        e.result  = c.mode ? c.start + n : c.start - n;
        e.lat     = e.enables + 2;
        e.t0      = t0;
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add(logic id, logic [W-1:0] start, logic mode, logic [W-1:0] steps, logic det);
        cmd_t c;
        c.start = start; c.mode = mode; c.steps = steps; c.det = det;
        if (id) pend1.push_back(c);
        else    pend0.push_back(c);
    endtask

    task automatic drive();
        req_valid  = {pend1.size() > 0, pend0.size() > 0};
        req0_start = pend0.size() > 0 ? pend0[0].start : '0;
        req0_mode  = pend0.size() > 0 ? pend0[0].mode  : 1'b0;
        req0_steps = pend0.size() > 0 ? pend0[0].steps : '0;
        req1_start = pend1.size() > 0 ? pend1[0].start : '0;
        req1_mode  = pend1.size() > 0 ? pend1[0].mode  : 1'b0;
        req1_steps = pend1.size() > 0 ? pend1[0].steps : '0;
        ctr_detect = (det_cnt == 1);
    endtask

    task automatic step();
        logic [1:0] g;
        cmd_t       c;
        @(posedge clk);
        cyc++;
        if (!reset) begin
            if (det_cnt > 0) det_cnt--;
            if (busy_left > 0) begin
                busy_left--;
            end else begin
                g = rr(req_valid, last);
                if (g != 2'b00) begin
                    c = g[1] ? pend1.pop_front() : pend0.pop_front();
                    cur = predict(g[1], c, cyc);
                    sb.push_back(cur);
                    busy_left = cur.lat;
                    last = g[1];
                    if (c.det) det_cnt = 3;
                    xfers++;
                end
            end
        end
        #1;
        drive();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1 check("outputs_in_reset",
                 {req_ready, ctr_enable, ctr_preload, ctr_mode, ctr_preload_data,
                  busy, done, done_id, done_result, done_early}, 32'd0);
        sb.delete();
        busy_left = 0;
        last      = 1'b1;
        det_cnt   = 0;
        ctr_detect = 1'b0;
        step();
        step();
        #2 reset = 1'b0;
    endtask

    task automatic run_until_idle(int max_cycles);
        int n = 0;
        while (!(pend0.size() == 0 && pend1.size() == 0 && busy_left == 0) && n < max_cycles) begin
            step();
            n++;
        end
        if (n >= max_cycles) begin
            miscompares++;
            $display("FAIL idle_timeout: still busy after %0d cycles", n);
        end
        step();
        step();
    endtask

    // monitor: per-cycle timeline checks plus scoreboard pop on done
    always @(negedge clk) begin
        logic exp_busy, exp_pre, exp_en, exp_done;
        exp_t e;
        if (reset) begin
            en_seen = 0;
        end else begin
            exp_busy = busy_left > 0;
            exp_pre  = exp_busy && busy_left == cur.lat;
            exp_en   = exp_busy && busy_left < cur.lat && busy_left > 1;
            exp_done = exp_busy && busy_left == 1;
            check("busy", busy, exp_busy);
            check("req_ready", req_ready, exp_busy ? 2'b00 : rr(req_valid, last));
            check("ctr_outputs", {ctr_enable, ctr_preload, ctr_mode, ctr_preload_data},
                  {exp_en, exp_pre, (exp_en | exp_pre) & cur.mode,
                   exp_pre ? cur.start : {W{1'b0}}});
            check("done_timing", done, exp_done);
            if (ctr_enable) en_seen++;
            if (done) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL done_unexpected: got done=1 expected no pending command (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("done_id", done_id, e.id);
                    check("done_result", done_result, e.result);
                    check("done_early", done_early, e.early);
                    check("enable_cycles", en_seen, e.enables);
                    check("latency", cyc - e.t0 + 1, e.lat);
                end
                en_seen = 0;
            end else begin
                check("done_fields_idle", {done_id, done_early, done_result}, 32'd0);
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        ctr_detect = 1'b0;
        drive();
        step();
        step();
        #2 reset = 1'b0;
        step();
        step();

        // preload 3, count up 4 steps
        add(1'b0, 4'd3, 1'b1, 4'd4, 1'b0);
        run_until_idle(40);

        // reset during activity, then tie-break from reset
        add(1'b1, 4'd6, 1'b0, 4'd7, 1'b0);
        step();
        step();
        step();
        do_reset();
        pend0.delete();
        pend1.delete();
        drive();
        step();
        add(1'b0, 4'd1, 1'b1, 4'd2, 1'b0);
        add(1'b1, 4'd5, 1'b0, 4'd3, 1'b0);
        run_until_idle(40);
        add(1'b0, 4'd8, 1'b0, 4'd1, 1'b0);
        add(1'b1, 4'd2, 1'b1, 4'd2, 1'b0);
        run_until_idle(40);

        // zero steps on requester 1
        add(1'b1, 4'd9, 1'b0, 4'd0, 1'b0);
        run_until_idle(40);

        // detect raised in the second RUN cycle
        add(1'b0, 4'd2, 1'b1, 4'd5, 1'b1);
        run_until_idle(40);

        // reset in the third RUN cycle aborts, then a normal command
        add(1'b0, 4'd4, 1'b1, 4'd8, 1'b0);
        n = xfers;
        for (int i = 0; i < 20 && xfers == n; i++) step();
        step();
        step();
        step();
        do_reset();
        drive();
        add(1'b1, 4'd12, 1'b1, 4'd3, 1'b0);
        run_until_idle(40);

        // maximum step count
        add(1'b0, 4'hA, 1'b1, 4'hF, 1'b0);
        add(1'b1, 4'h1, 1'b0, 4'hF, 1'b0);
        run_until_idle(80);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 30) begin
                logic id;
                id = 1'(($urandom_range(0, 1)));
                if ((id ? pend1.size() : pend0.size()) < 3)
                    add(id, W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                        W'($urandom_range(0, 15)), 1'b0);
            end
            step();
        end
        run_until_idle(300);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
